// File: rtl/m_issue_pkg.sv
// Shared definitions for the M-extension issue stage: FSM encoding, AluOp codes
// and op classification.
package m_issue_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ALU_OP_WIDTH = 5;

  typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DIV_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_ABORT    = 2'd3;

  // The all-zero code doubles as the idle no-op seen by the M wrapper.
  localparam alu_op_t ALU_NOP    = 5'd0;
  localparam alu_op_t ALU_MUL    = 5'd16;
  localparam alu_op_t ALU_MULH   = 5'd17;
  localparam alu_op_t ALU_MULHSU = 5'd18;
  localparam alu_op_t ALU_MULHU  = 5'd19;
  localparam alu_op_t ALU_DIV    = 5'd20;
  localparam alu_op_t ALU_DIVU   = 5'd21;
  localparam alu_op_t ALU_REM    = 5'd22;
  localparam alu_op_t ALU_REMU   = 5'd23;

  function automatic logic is_div(input alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/m_result_cache.sv
// One-entry memo of the last completed divide {op, s1, s2, result}; only built
// into m_issue_ctrl when M_DIVREM_CACHE_EN is defined.
module m_result_cache
  import m_issue_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int OP_W   = ALU_OP_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   lookup_op,
  input  logic [DATA_W-1:0] lookup_s1,
  input  logic [DATA_W-1:0] lookup_s2,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill,
  input  logic [OP_W-1:0]   fill_op,
  input  logic [DATA_W-1:0] fill_s1,
  input  logic [DATA_W-1:0] fill_s2,
  input  logic [DATA_W-1:0] fill_data
);

  logic              valid;
  logic [OP_W-1:0]   tag_op;
  logic [DATA_W-1:0] tag_s1;
  logic [DATA_W-1:0] tag_s2;
  logic [DATA_W-1:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
    end
  end

  // NOTE: the payload is not reset; the valid bit alone decides whether it is
  // trusted, so the wide storage needs no reset fan-out.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_op <= fill_op;
      tag_s1 <= fill_s1;
      tag_s2 <= fill_s2;
      data   <= fill_data;
    end
  end

  assign hit      = valid && (tag_op == lookup_op) && (tag_s1 == lookup_s1) && (tag_s2 == lookup_s2);
  assign hit_data = data;

endmodule

// File: rtl/m_issue_ctrl.sv
// Issue/sequencing stage in front of the RV32M wrapper: MUL passes straight
// through, DIV is latched and stalls EX. Optional divide memo: M_DIVREM_CACHE_EN.
module m_issue_ctrl
  import m_issue_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int OP_W   = ALU_OP_WIDTH,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_AluOp,
  input  logic [DATA_W-1:0] ex_s1,
  input  logic [DATA_W-1:0] ex_s2,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              flush,
  output logic [DATA_W-1:0] m_s1,
  output logic [DATA_W-1:0] m_s2,
  output logic [OP_W-1:0]   m_AluOp,
  input  logic              m_div_ready,
  input  logic [DATA_W-1:0] m_data,
  output logic              ex_stall,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] lat_s1;
  logic [DATA_W-1:0] lat_s2;
  logic [OP_W-1:0]   lat_op;
  logic [RD_W-1:0]   lat_rd;

  logic              ex_div;
  logic              ex_mul;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_data;
  logic              div_accept;
  logic              div_bypass;
  logic              div_finish;

  assign ex_div = ex_valid && is_div(ex_AluOp);
  assign ex_mul = ex_valid && !is_div(ex_AluOp) && (ex_AluOp != '0);

  // A flushed divide in IDLE is simply never accepted.
  assign div_accept = (state == ST_IDLE) && ex_div && !flush && !cache_hit;
  assign div_bypass = (state == ST_IDLE) && ex_div && !flush && cache_hit;
  assign div_finish = (state == ST_DIV_BUSY) && m_div_ready && !flush;

`ifdef M_DIVREM_CACHE_EN
  m_result_cache #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_cache (
    .clk       (clk),
    .rst       (rst),
    .lookup_op (ex_AluOp),
    .lookup_s1 (ex_s1),
    .lookup_s2 (ex_s2),
    .hit       (cache_hit),
    .hit_data  (cache_data),
    .fill      (div_finish),
    .fill_op   (lat_op),
    .fill_s1   (lat_s1),
    .fill_s2   (lat_s2),
    .fill_data (m_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    m_s1      = lat_s1;
    m_s2      = lat_s2;
    m_AluOp   = '0;
    ex_stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_mul || div_accept) begin
          m_s1    = ex_s1;
          m_s2    = ex_s2;
          m_AluOp = ex_AluOp;
        end
        if (div_accept) begin
          ex_stall  = 1'b1;
          state_nxt = ST_DIV_BUSY;
        end
      end
      ST_DIV_BUSY: begin
        m_AluOp  = lat_op;
        ex_stall = 1'b1;
        if (flush)            state_nxt = ST_ABORT;
        else if (m_div_ready) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ABORT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_s1   <= '0;
      lat_s2   <= '0;
      lat_op   <= '0;
      lat_rd   <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      state    <= state_nxt;
      wb_valid <= 1'b0;
      if (div_accept) begin
        lat_s1 <= ex_s1;
        lat_s2 <= ex_s2;
        lat_op <= ex_AluOp;
        lat_rd <= ex_rd;
      end
      if ((state == ST_IDLE) && ex_mul && !flush) begin
        wb_valid <= 1'b1;
        wb_rd    <= ex_rd;
        wb_data  <= m_data;
      end
      if (div_bypass) begin
        wb_valid <= 1'b1;
        wb_rd    <= ex_rd;
        wb_data  <= cache_data;
      end
      if (div_finish) begin
        wb_valid <= 1'b1;
        wb_rd    <= lat_rd;
        wb_data  <= m_data;
      end
    end
  end

endmodule

// File: doc/m_issue_ctrl.md
# m_issue_ctrl

Sequencing stage directly upstream of the RV32M unit wrapper. Accepts M-extension operations from the EX stage, drives stable operands and op code into the multiply/divide wrapper, and stalls the pipeline for the multi-cycle divider. It captures the wrapper's result into a registered writeback slot and handles flushes that arrive mid-divide.

## Interface
- DATA_W, default `DATA_WIDTH (32): operand and result width.
- OP_W, default `ALU_OP_WIDTH: AluOp code width.
- RD_W, default 5: destination register index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- ex_valid  in  1  EX holds an M-type op this cycle.
- ex_AluOp  in  OP_W  M op code (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- ex_s1, ex_s2  in  DATA_W  source operands.
- ex_rd  in  RD_W  destination register.
- flush  in  1  kill the in-flight op (branch or trap).
- m_s1, m_s2  out  DATA_W  operands to the M wrapper.
- m_AluOp  out  OP_W  op code to the M wrapper; all-zero no-op when idle.
- m_div_ready  in  1  divider result valid.
- m_data  in  DATA_W  wrapper result.
- ex_stall  out  1  hold IF/ID/EX.
- wb_valid  out  1  one-cycle pulse: result is available.
- wb_rd  out  RD_W  destination of the result.
- wb_data  out  DATA_W  result.

## Operation
- FSM states: IDLE, DIV_BUSY, DONE, ABORT.
- **IDLE**
  - MUL-class op with ex_valid: pass ex_s1/ex_s2/ex_AluOp combinationally to m_*.
  - Register m_data into wb_data and ex_rd into wb_rd. Assert wb_valid the next cycle. No stall.
  - DIV-class op with ex_valid: latch s1, s2, op and rd into operand registers, drive m_* from those registers, go to DIV_BUSY.
  - ex_stall asserts combinationally in the same cycle.
- **DIV_BUSY**
  - m_* held constant from the latched registers.
  - ex_stall = 1.
  - On m_div_ready: capture m_data and the latched rd, go to DONE.
- **DONE**
  - wb_valid = 1 for exactly one cycle.
  - ex_stall = 0, so EX advances.
  - m_AluOp = no-op. Next state is IDLE.
  - A new op presented in this cycle is not accepted until IDLE.
- **ABORT**
  - Entered when flush = 1 in DIV_BUSY.
  - Drives no-op for one cycle so the divider drops its run. m_div_ready is ignored. ex_stall = 0.
  - Next state is IDLE. No wb_valid is produced for the killed op.
- flush in IDLE with a MUL op suppresses that cycle's wb_valid.
- flush has priority over m_div_ready arriving in the same cycle: no writeback, go to ABORT.
- ex_valid = 0 in IDLE: m_AluOp = no-op, nothing is registered.
- Divide-by-zero and signed overflow results come from the divider unchanged. This block applies no special casing.

## Timing
- Reset values: state IDLE; wb_valid 0; wb_rd 0; wb_data 0; m_s1/m_s2 0; latched registers 0; ex_stall 0; m_AluOp no-op.
- Reset mid-divide returns to IDLE on that edge with no writeback.
- MUL latency: 1 cycle from ex_valid to wb_valid. Throughput: 1 per cycle.
- DIV latency: divider cycles + 1 (DONE), counted from accept.
  - ex_stall is high from the accept cycle through the m_div_ready cycle inclusive.
- wb_* are registered. wb_rd/wb_data hold their last value when wb_valid = 0.

## Configuration
- M_DIVREM_CACHE_EN
  - Defined: a one-entry cache holds {op, s1, s2, result} of the last completed divide. A DIV-class op in IDLE that matches all fields bypasses the divider and produces wb_valid next cycle with the cached result, no stall.
    - Cache is invalidated on rst.
    - ABORT does not update the cache.
  - Undefined: every divide runs the divider. No cache storage exists.

## Structure
- Shared package / Define.v additions: FSM state encoding, the no-op AluOp constant, and an is_div(op) classification function.
- One sub-module when the macro is enabled: m_result_cache (lookup, hit, fill).

## Test plan
- MUL 7×6, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=42, ex_stall never asserted.
- DIVU 100/7, rd=3, divider ready after 33 cycles -> ex_stall high for 34 cycles, m_s1/m_s2 stable, then wb_valid=1 with wb_data=14, wb_rd=3.
- DIV in progress, flush at cycle 10 -> ABORT, m_AluOp=0 for 1 cycle, no wb_valid, ex_stall drops, and a following MUL 3×3 writes back 9.
- flush and m_div_ready in the same cycle -> no wb_valid, state goes to ABORT.
- rst during DIV_BUSY -> all outputs at reset values the next cycle.
- With M_DIVREM_CACHE_EN: REMU 100/7 twice -> first writes 2 after the full latency; second writes 2 one cycle after issue with no stall.
